gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Self-running truth-table exerciser for the nand2tetris gate library. It sits directly upstream of a gate under test such as andGate, driving every input combination onto the gate's inputs. It also sits directly downstream of that gate, sampling its output after a settle delay and comparing it against a parameterised expected truth table. The result is a pass/fail summary, so gate checks run as synthesizable hardware rather than as hand-written stimulus sequences.

## Interface
- N_INPUTS, default 2: number of gate inputs; 1..4 supported.
- SETTLE_CYCLES, default 2: cycles each vector is held before sampling; must be ≥1.
- EXPECTED, default 4'b1000 (AND): 2^N_INPUTS-bit truth table; bit v = expected output for input vector v.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start a run; honoured only in IDLE.
- dut_y_i  in  1  output of the gate under test.
- dut_in_o  out  N_INPUTS  vector driven to the gate; bit 0 → A_i, bit 1 → B_i, and so on.
- busy_o  out  1  high while a run is in progress.
- done_o  out  1  one-cycle pulse at end of run.
- pass_o  out  1  high if the last run had zero mismatches; held until next start.
- err_count_o  out  N_INPUTS+1  mismatches in the last run.
- fail_vec_o  out  2^N_INPUTS  bit v set if vector v mismatched.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: dut_in_o=0, busy_o=0.
  - start_i=1 → SETTLE with vec=0.
  - On the same edge: err_count_o, fail_vec_o and pass_o clear.
- SETTLE: dut_in_o=vec. Settle counter loads SETTLE_CYCLES-1 on entry and decrements each cycle. Leaves for SAMPLE when the counter is 0.
- SAMPLE: compares dut_y_i with EXPECTED[vec].
  - On mismatch: err_count_o increments and fail_vec_o[vec] is set.
  - If vec = 2^N-1 → DONE. Otherwise vec+1 → SETTLE.
- DONE: for one cycle, done_o=1, busy_o=0 and pass_o=(err_count_o==0). Then → IDLE.
- Holding dut_in_o: it keeps the final vector through DONE and returns to 0 in IDLE.
- vec counter is N_INPUTS bits; the terminal compare happens before increment, so it never wraps.
- err_count_o saturates nowhere; the maximum value 2^N fits in N+1 bits.
- start_i while busy_o=1 or in DONE: ignored, no restart.

## Timing
- Reset values (asynchronous, immediate on rst_ni low): state IDLE, dut_in_o=0, busy_o=0, done_o=0, pass_o=0, err_count_o=0, fail_vec_o=0, counters 0.
- Reset mid-run: run aborted with no done_o pulse; outputs go to reset values.
- Start edge: start_i sampled high at edge k gives busy_o=1 and dut_in_o=0 from edge k.
- Per-vector latency: SETTLE_CYCLES+1 cycles. dut_y_i is sampled SETTLE_CYCLES+1 edges after the vector is applied.
- Run length: busy_o is high for exactly 2^N·(SETTLE_CYCLES+1) cycles, then done_o is high for 1 cycle.
- Default parameters: busy_o is high for 12 cycles and done_o is high during the 13th cycle after edge k.
- dut_y_i is assumed combinational from dut_in_o; it must be stable within SETTLE_CYCLES.

## Configuration
- GATE_EXERCISER_STOP_ON_FAIL_EN
  - Defined: on the first mismatch in SAMPLE, the FSM goes directly to DONE. dut_in_o holds the failing vector through DONE, err_count_o=1, and fail_vec_o has exactly one bit set.
  - Undefined: all 2^N vectors always run, and all mismatches are recorded.

## Structure
- Shared package gate_exerciser_pkg holds:
  - state enum typedef (IDLE, SETTLE, SAMPLE, DONE);
  - truth-table constants TT_AND=4'b1000, TT_NAND=4'b0111, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_NOT=2'b01.
- One sub-module, settle_timer: a loadable down-counter with a zero flag, width $clog2(SETTLE_CYCLES+1).

## Test plan
- **AND pass:** andGate as DUT, defaults, start pulse → after 12 busy cycles, done_o pulses; pass_o=1, err_count_o=0, fail_vec_o=4'b0000.
- **Wrong gate:** NAND model as DUT with EXPECTED=TT_AND → pass_o=0, err_count_o=4, fail_vec_o=4'b1111.
- **Stuck-at-0 output:** dut_y_i tied 0 → err_count_o=1, fail_vec_o=4'b1000. dut_in_o sequence seen by the gate is 0,1,2,3, each held 3 cycles.
- **Start while busy:** start_i pulsed again at cycle 5 of a run → no restart; done_o arrives at the original cycle 13, and results are unchanged.
- **Reset mid-run:** rst_ni low at cycle 7 → outputs zero immediately; no done_o. A fresh start then completes normally with pass_o=1.
- **Stop-on-fail (GATE_EXERCISER_STOP_ON_FAIL_EN defined):** OR model vs TT_AND → DONE after vector 1 (cycle 7), with dut_in_o=2'b01, err_count_o=1, fail_vec_o=4'b0010.

Source files
------------

// File: rtl/gate_exerciser_pkg.sv
// Shared types and reference truth tables for the gate exerciser.
// Truth-table bit v is the expected gate output for input vector v.
package gate_exerciser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [1:0] TT_NOT  = 2'b01;

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module settle_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_exerciser.sv
// Self-running truth-table exerciser: walks every input vector, samples the gate, tallies mismatches.
// Optional GATE_EXERCISER_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
//
// state  | meaning
// IDLE   | waiting for start_i, dut_in_o driven to 0
// SETTLE | vector applied, waiting for the gate output to settle
// SAMPLE | compare dut_y_i with the expected bit, advance or finish
// DONE   | one-cycle done_o pulse, results valid
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int                        N_INPUTS      = 2,
  parameter int                        SETTLE_CYCLES = 2,
  parameter logic [2**N_INPUTS-1:0]    EXPECTED      = TT_AND
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     dut_y_i,
  output logic [N_INPUTS-1:0]      dut_in_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [N_INPUTS:0]        err_count_o,
  output logic [2**N_INPUTS-1:0]   fail_vec_o
);

  localparam int              N_VEC       = 2**N_INPUTS;
  localparam int              TW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS:0] ERR_ONE   = 1;

  state_t              state_q;
  logic [N_INPUTS-1:0] vec_q;
  logic [N_INPUTS:0]   err_q;
  logic [N_VEC-1:0]    fail_q;
  logic                pass_q;
  logic                timer_load;
  logic                timer_zero;
  logic                mismatch;
  logic                last_vec;
  logic                stop;

  assign mismatch = (dut_y_i != EXPECTED[vec_q]);
  assign last_vec = (vec_q == '1);

`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
  assign stop = last_vec | mismatch;
`else
  assign stop = last_vec;
`endif

  // Reload on run start and on every move from SAMPLE back to SETTLE.
  assign timer_load = ((state_q == ST_IDLE) && start_i) ||
                      ((state_q == ST_SAMPLE) && !stop);

  settle_timer #(
    .WIDTH(TW)
  ) u_settle_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load),
    .load_val_i (SETTLE_LOAD),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_SETTLE;
            vec_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (timer_zero) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_q         <= err_q + ERR_ONE;
            fail_q[vec_q] <= 1'b1;
          end
          if (stop) begin
            state_q <= ST_DONE;
            pass_q  <= !mismatch && (err_q == '0);
          end else begin
            state_q <= ST_SETTLE;
            vec_q   <= vec_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dut_in_o    = (state_q == ST_IDLE) ? '0 : vec_q;
  assign busy_o      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_vec_o  = fail_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: a truth-table gate model feeds dut_y_i; expectations come from XOR of tables.
module tb_gate_exerciser;
  import gate_exerciser_pkg::*;

  localparam int HOLD = 3;  // settle cycles + sample cycle per vector

  logic       clk;
  logic       rst_ni;
  logic       start;
  logic       dut_y;
  logic [1:0] dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [3:0] gate_tt;

  int n_vec;
  int n_err;

  gate_exerciser #(
    .N_INPUTS      (2),
    .SETTLE_CYCLES (2),
    .EXPECTED      (TT_AND)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start),
    .dut_y_i     (dut_y),
    .dut_in_o    (dut_in),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_count_o (err_count),
    .fail_vec_o  (fail_vec)
  );

  assign dut_y = gate_tt[dut_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_ni = 1'b0;
    start  = 1'b0;
    gate_tt = TT_AND;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, pass, dut_in, err_count, fail_vec} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 000", {busy, done, pass, dut_in, err_count, fail_vec});
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, dut_in} !== 4'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h expected 0", {busy, done, dut_in});
    end
  endtask

  // Run one full exercise against gate table tt; optionally poke start mid-run or during DONE.
  task automatic run_gate(input string name, input logic [3:0] tt, input int poke_cycle,
                          input bit start_in_done);
    logic [3:0] mis;
    logic [3:0] exp_fail;
    int first, nrun, busy_len, done_cyc, exp_err, exp_in;
    bit exp_pass;
    gate_tt = tt;
    mis = tt ^ TT_AND;
    first = -1;
    for (int i = 0; i < 4; i++) if (mis[i] && first < 0) first = i;
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
    if (first >= 0) begin
      nrun = first + 1;
      exp_err = 1;
      exp_fail = 4'b0001 << first;
    end else begin
      nrun = 4;
      exp_err = 0;
      exp_fail = 4'b0000;
    end
`else
    nrun = 4;
    exp_err = $countones(mis);
    exp_fail = mis;
`endif
    exp_pass = (exp_err == 0);
    busy_len = nrun * HOLD;
    done_cyc = busy_len + 1;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= done_cyc; c++) begin
      @(negedge clk);
      exp_in = (c <= busy_len) ? (c - 1) / HOLD : nrun - 1;
      n_vec++;
      if ({busy, done, dut_in} !== {(c <= busy_len), (c == done_cyc), 2'(exp_in)}) begin
        n_err++;
        $display("FAIL %s cycle %0d busy/done/in: got %b%b %0d expected %b%b %0d", name, c,
                 busy, done, dut_in, (c <= busy_len), (c == done_cyc), exp_in);
      end
      if (c == done_cyc) begin
        n_vec++;
        if ({pass, err_count, fail_vec} !== {exp_pass, 3'(exp_err), exp_fail}) begin
          n_err++;
          $display("FAIL %s results pass/err/fail: got %b %0d %b expected %b %0d %b", name,
                   pass, err_count, fail_vec, exp_pass, exp_err, exp_fail);
        end
      end
      if (c == poke_cycle || (start_in_done && c == done_cyc)) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done, dut_in, pass, err_count, fail_vec} !== {4'b0000, exp_pass, 3'(exp_err), exp_fail}) begin
      n_err++;
      $display("FAIL %s after_done: got busy=%b done=%b in=%0d pass=%b err=%0d fail=%b", name,
               busy, done, dut_in, pass, err_count, fail_vec);
    end
  endtask

  task automatic test_fixed_gates();
    run_gate("and_pass", TT_AND, 0, 1'b0);
    run_gate("nand_wrong", TT_NAND, 0, 1'b0);
    run_gate("stuck0", 4'b0000, 0, 1'b0);
    run_gate("or_gate", TT_OR, 0, 1'b0);
    run_gate("xor_gate", TT_XOR, 0, 1'b0);
  endtask

  task automatic test_random_gates();
    for (int i = 0; i < 10; i++) run_gate("random_tt", 4'($urandom_range(0, 15)), 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_gate("start_busy_and", TT_AND, 5, 1'b0);
    run_gate("start_busy_nor", TT_NOR, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_gate("start_in_done", TT_NAND, 0, 1'b1);
    run_gate("after_done_start", TT_AND, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    gate_tt = TT_NAND;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, pass, dut_in, err_count, fail_vec} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_mid_run: got %h expected 000", {busy, done, pass, dut_in, err_count, fail_vec});
    end
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done} !== 2'b00) begin
        n_err++;
        $display("FAIL no_done_after_abort cycle %0d: got %b expected 00", c, {busy, done});
      end
    end
    run_gate("fresh_after_reset", TT_AND, 0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fixed_gates();
    test_random_gates();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
